// File: rtl/slot_allocator.sv
// Slot allocator: hands out the highest-index free slot, grant registered one cycle after request.
// Backpressure: requests while full (or during flush) are dropped; the requester must re-assert.
module priorityEncoder #(
    parameter  int WIDTH   = 8,
    localparam int IDWIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   in,
    output logic [IDWIDTH-1:0] out,
    output logic               found
);
    // Ascending scan with last-write-wins yields the highest-index zero bit.
    always_comb begin
        out   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!in[i]) begin
                out   = IDWIDTH'(i);
                found = 1'b1;
            end
        end
    end
endmodule

module slot_allocator #(
    parameter  int WIDTH   = 8,
    localparam int IDWIDTH = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [IDWIDTH-1:0] alloc_id,
    input  logic               free_valid,
    input  logic [IDWIDTH-1:0] free_id,
    input  logic               flush,
    output logic [WIDTH-1:0]   occupancy,
    output logic [IDWIDTH:0]   count,
    output logic               full,
    output logic               empty,
    output logic               err_free
);
    localparam logic [IDWIDTH:0] WIDTH_V = (IDWIDTH + 1)'(WIDTH);

    logic [IDWIDTH-1:0] sel_id;
    logic               sel_found;
    logic               accept;
    logic               free_in_range;
    logic               free_hit;
    logic               free_err;
    logic [WIDTH-1:0]   occ_set;
    logic [WIDTH-1:0]   occ_clr;

    priorityEncoder #(.WIDTH(WIDTH)) u_penc (
        .in    (occupancy),
        .out   (sel_id),
        .found (sel_found)
    );

    assign full  = &occupancy;
    assign empty = ~|occupancy;

    // Selection works on pre-free occupancy, so a slot freed this cycle is never granted this cycle.
    always_comb begin
        accept        = alloc_req && sel_found && !flush;
        free_in_range = ({1'b0, free_id} < WIDTH_V);
        free_hit      = 1'b0;
        if (free_valid && !flush && free_in_range) begin
            free_hit = occupancy[free_id];
        end
        free_err = free_valid && !flush && !free_hit;
        occ_set  = accept   ? (WIDTH'(1) << sel_id)  : '0;
        occ_clr  = free_hit ? (WIDTH'(1) << free_id) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
            count     <= '0;
            alloc_gnt <= 1'b0;
            alloc_id  <= '0;
            err_free  <= 1'b0;
        end else begin
            if (flush) begin
                occupancy <= '0;
                count     <= '0;
                alloc_gnt <= 1'b0;
            end else begin
                occupancy <= (occupancy & ~occ_clr) | occ_set;
                count     <= count + (IDWIDTH + 1)'(accept) - (IDWIDTH + 1)'(free_hit);
                alloc_gnt <= accept;
                if (accept) begin
                    alloc_id <= sel_id;
                end
            end
            err_free <= err_free | free_err;
        end
    end
endmodule

// File: tb/tb_slot_allocator.sv
// Directed plus random bench for slot_allocator against a slot-array reference model.
module tb_slot_allocator;
    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [IW-1:0] alloc_id;
    logic          free_valid;
    logic [IW-1:0] free_id;
    logic          flush;
    logic [W-1:0]  occupancy;
    logic [IW:0]   count;
    logic          full;
    logic          empty;
    logic          err_free;

    int total = 0;
    int bad   = 0;

    // Reference model state: one entry per slot, plus grant/error bookkeeping.
    int m_slot[W];
    int m_gnt;
    int m_id;
    int m_err;

    slot_allocator #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_id   (alloc_id),
        .free_valid (free_valid),
        .free_id    (free_id),
        .flush      (flush),
        .occupancy  (occupancy),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .err_free   (err_free)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int rq, input int fv, input int fid, input int fl, input int rst);
        int used;
        int pick;
        used = 0;
        pick = -1;
        for (int i = 0; i < W; i++) used += m_slot[i];
        for (int i = W - 1; i >= 0; i--) begin
            if (m_slot[i] == 0) begin
                pick = i;
                break;
            end
        end
        if (rst != 0) begin
            for (int i = 0; i < W; i++) m_slot[i] = 0;
            m_gnt = 0;
            m_id  = 0;
            m_err = 0;
        end else if (fl != 0) begin
            for (int i = 0; i < W; i++) m_slot[i] = 0;
            m_gnt = 0;
        end else begin
            if (fv != 0) begin
                if (fid < W && m_slot[fid] == 1) m_slot[fid] = 0;
                else m_err = 1;
            end
            if (rq != 0 && used < W) begin
                m_slot[pick] = 1;
                m_gnt = 1;
                m_id  = pick;
            end else begin
                m_gnt = 0;
            end
        end
    endtask

    task automatic step(input int rq, input int fv, input int fid, input int fl, input int rst);
        logic [W-1:0] e_occ;
        int           e_cnt;
        reset      = (rst != 0);
        alloc_req  = (rq != 0);
        free_valid = (fv != 0);
        free_id    = IW'(fid);
        flush      = (fl != 0);
        model_step(rq, fv, fid, fl, rst);
        @(posedge clk);
        #1;
        e_occ = '0;
        e_cnt = 0;
        for (int i = 0; i < W; i++) begin
            e_occ[i] = (m_slot[i] != 0);
            e_cnt += m_slot[i];
        end
        chk("alloc_gnt", 32'(alloc_gnt), 32'(m_gnt));
        chk("alloc_id",  32'(alloc_id),  32'(m_id));
        chk("occupancy", 32'(occupancy), 32'(e_occ));
        chk("count",     32'(count),     32'(e_cnt));
        chk("full",      32'(full),      32'(e_cnt == W));
        chk("empty",     32'(empty),     32'(e_cnt == 0));
        chk("err_free",  32'(err_free),  32'(m_err));
    endtask

    initial begin
        reset = 1'b1; alloc_req = 1'b0; free_valid = 1'b0; free_id = '0; flush = 1'b0;
        for (int i = 0; i < W; i++) m_slot[i] = 0;
        m_gnt = 0; m_id = 0; m_err = 0;

        // Reset with a competing request: no grant.
        step(1, 0, 0, 0, 1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_gnt", 32'(alloc_gnt), 32'd0);

        // Three grants: 7, 6, 5.
        step(1, 0, 0, 0, 0);
        chk("g1_id", 32'(alloc_id), 32'd7);
        step(1, 0, 0, 0, 0);
        chk("g2_id", 32'(alloc_id), 32'd6);
        step(1, 0, 0, 0, 0);
        chk("g3_id", 32'(alloc_id), 32'd5);
        chk("g3_occ", 32'(occupancy), 32'h0E0);
        chk("g3_cnt", 32'(count), 32'd3);

        // From empty, hold request for 9 cycles.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_cnt", 32'(count), 32'd8);
        chk("fill_gnt9", 32'(alloc_gnt), 32'd0);

        // Full with simultaneous free and request: no bypass.
        step(1, 1, 3, 0, 0);
        chk("nobypass_gnt", 32'(alloc_gnt), 32'd0);
        chk("nobypass_occ", 32'(occupancy), 32'h0F7);
        step(1, 0, 0, 0, 0);
        chk("refill_id", 32'(alloc_id), 32'd3);
        chk("refill_full", 32'(full), 32'd1);

        // Bad free leaves occupancy alone and sets sticky error.
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        chk("badfree_err", 32'(err_free), 32'd1);
        chk("badfree_occ", 32'(occupancy), 32'h080);
        step(0, 0, 0, 0, 0);
        chk("err_sticky", 32'(err_free), 32'd1);
        step(0, 1, 7, 0, 0);
        chk("goodfree_occ", 32'(occupancy), 32'h000);

        // Flush beats alloc and free.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        chk("pre_flush_cnt", 32'(count), 32'd5);
        step(1, 1, 7, 1, 0);
        chk("flush_occ", 32'(occupancy), 32'h000);
        chk("flush_gnt", 32'(alloc_gnt), 32'd0);
        chk("flush_err", 32'(err_free), 32'd1);

        // Mid-operation reset discards everything.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("midrst_cnt", 32'(count), 32'd0);
        step(1, 0, 0, 0, 0);
        chk("postrst_id", 32'(alloc_id), 32'd7);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(99) < 60) ? 1 : 0,
                 ($urandom_range(99) < 40) ? 1 : 0,
                 int'($urandom_range(W - 1)),
                 ($urandom_range(99) < 3) ? 1 : 0,
                 ($urandom_range(99) < 1) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
